// File: rtl/qspi_pkg.sv
// Shared types and helpers for the QSPI shift engine.
package qspi_pkg;

    // Lane mode of a transfer; QSPI_RSVD is rejected at load time.
    typedef enum logic [1:0] {
        QSPI_SINGLE,
        QSPI_DUAL,
        QSPI_QUAD,
        QSPI_RSVD
    } qspi_mode_e;

    // Shift engine control states.
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } qspi_state_e;

    // Number of data lanes used per beat in a given mode.
    function automatic int unsigned lanes_of(qspi_mode_e m);
        case (m)
            QSPI_DUAL: return 2;
            QSPI_QUAD: return 4;
            default:   return 1;
        endcase
    endfunction

endpackage

// File: rtl/qspi_shift_engine.sv
// MSB-first QSPI serialiser/deserialiser with its own beat counter.
// A transfer moves 1..DATA_W/8 bytes over 1, 2 or 4 lanes, one beat per shift_en.
module qspi_shift_engine
    import qspi_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [LEN_W-1:0]  len_m1,
    input  logic [1:0]        mode,
    input  logic              dir,
    input  logic              load,
    input  logic              shift_en,
    input  logic              abort,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              load_err
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(DATA_W);

    qspi_state_e       state;
    qspi_mode_e        mode_q;
    logic              dir_q;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] rx_mask;
    logic [CNT_W-1:0]  beat_cnt;

    qspi_mode_e        mode_in;
    int unsigned       len_bytes;
    int unsigned       load_bits;
    int unsigned       load_beats;
    logic [DATA_W-1:0] load_shifted;
    logic [DATA_W-1:0] load_mask;
    logic [CNT_W-1:0]  load_cnt;
    logic [DATA_W-1:0] shift_nxt;

    assign mode_in = qspi_mode_e'(mode);

    // Load-time decode: clamp length, left-justify tx data, size the beat count.
    always_comb begin
        len_bytes = 32'(len_m1) + 1;
        if (len_bytes > NBYTES) begin
            len_bytes = NBYTES;
        end
        load_bits = len_bytes * 8;
        case (mode_in)
            QSPI_DUAL: load_beats = load_bits >> 1;
            QSPI_QUAD: load_beats = load_bits >> 2;
            default:   load_beats = load_bits;
        endcase
        load_shifted = data_in << (DATA_W - load_bits);
        load_mask    = {DATA_W{1'b1}} >> (DATA_W - load_bits);
        load_cnt     = CNT_W'(load_beats - 1);
    end

    // Next shift register value for one beat: zero fill on tx, lane capture on rx.
    always_comb begin
        shift_nxt = shift_reg << lanes_of(mode_q);
        if (dir_q) begin
            case (mode_q)
                QSPI_DUAL: shift_nxt = {shift_reg[DATA_W-3:0], io_in[1:0]};
                QSPI_QUAD: shift_nxt = {shift_reg[DATA_W-5:0], io_in[3:0]};
                default:   shift_nxt = {shift_reg[DATA_W-2:0], io_in[1]};
            endcase
        end
    end

    // Control FSM, beat counter, shift register and received-word capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            mode_q    <= QSPI_SINGLE;
            dir_q     <= 1'b0;
            shift_reg <= '0;
            rx_mask   <= '0;
            beat_cnt  <= '0;
            rx_data   <= '0;
            load_err  <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (abort) begin
                // Abort beats everything, including a load issued in the same cycle.
                state    <= StIdle;
                beat_cnt <= '0;
            end else begin
                case (state)
                    StIdle: begin
                        if (load) begin
                            if (mode_in == QSPI_RSVD) begin
                                load_err <= 1'b1;
                            end else begin
                                state     <= StShift;
                                mode_q    <= mode_in;
                                dir_q     <= dir;
                                shift_reg <= load_shifted;
                                rx_mask   <= load_mask;
                                beat_cnt  <= load_cnt;
                            end
                        end
                    end
                    StShift: begin
                        if (shift_en) begin
                            shift_reg <= shift_nxt;
                            if (beat_cnt == '0) begin
                                state <= StDone;
                                if (dir_q) begin
                                    rx_data <= shift_nxt & rx_mask;
                                end
                            end else begin
                                beat_cnt <= beat_cnt - CNT_W'(1);
                            end
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    // Pad drive: only a transmit in progress drives lanes, MSB on the highest used lane.
    always_comb begin
        io_out = '0;
        io_oe  = '0;
        if (state == StShift && !dir_q) begin
            case (mode_q)
                QSPI_SINGLE: begin
                    io_out[0] = shift_reg[DATA_W-1];
                    io_oe     = 4'b0001;
                end
                QSPI_DUAL: begin
                    io_out[1:0] = shift_reg[DATA_W-1 -: 2];
                    io_oe       = 4'b0011;
                end
                QSPI_QUAD: begin
                    io_out = shift_reg[DATA_W-1 -: 4];
                    io_oe  = 4'b1111;
                end
                default: begin
                    io_out = '0;
                    io_oe  = '0;
                end
            endcase
        end
    end

    // Status decode from the registered state.
    always_comb begin
        busy = (state == StShift) || (state == StDone);
        done = (state == StDone);
    end

endmodule
